// File: rtl/rl_pkg.sv
// rtl/rl_pkg.sv - shared types and helpers for the router-logic merge arbiter
package rl_pkg;

  localparam int WIDTH       = 11;
  localparam int TYPE_BIT    = 0;
  localparam int DEST_LSB    = 1;
  localparam int DEST_MSB    = 3;
  localparam int PAYLOAD_LSB = 4;

  // Packet layout, MSB first: payload[10:4], dest[3:1], type[0]
  typedef struct packed {
    logic [6:0] payload;
    logic [2:0] dest;
    logic       pkt_type;
  } rl_pkt_t;

  typedef enum logic {
    OS_EMPTY = 1'b0,
    OS_FULL  = 1'b1
  } os_state_t;

  // Round-robin scan position: (base + off) mod n, narrowed to an input index
  function automatic logic [1:0] rr_index(input logic [1:0] base, input int off, input int n);
    return 2'((int'(base) + off) % n);
  endfunction

endpackage

// File: rtl/rl_merge_arb_if.sv
// rtl/rl_merge_arb_if.sv - merge arbiter input/output stream bundle
interface rl_merge_arb_if #(
  parameter int WIDTH  = 11,
  parameter int NUM_IN = 3,
  parameter int CNT_W  = 16
);

  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [1:0]              out_src;
  logic [CNT_W-1:0]        pkt_count;

  // Traffic side: sources feeding the inputs and the sink draining the output
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src, pkt_count
  );

  // Arbiter side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src, pkt_count
  );

endinterface

// File: rtl/rl_fifo.sv
// rtl/rl_fifo.sv - per-input synchronous FIFO with wrap-bit pointers
module rl_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // The extra pointer bit tells a full FIFO from an empty one when the indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset discards any buffered packets
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents are meaningless until the pointers say otherwise
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rl_merge_arb.sv
// rtl/rl_merge_arb.sv - round-robin merge of per-direction packet streams into one output
module rl_merge_arb
  import rl_pkg::*;
#(
  parameter int WIDTH      = rl_pkg::WIDTH,
  parameter int NUM_IN     = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          reset,
  rl_merge_arb_if.slave bus
);

  logic [NUM_IN-1:0] push;
  logic [NUM_IN-1:0] pop;
  logic [NUM_IN-1:0] full;
  logic [NUM_IN-1:0] empty;
  logic [WIDTH-1:0]  head [NUM_IN];

  os_state_t         state;
  logic [1:0]        last_grant;
  logic [WIDTH-1:0]  out_data_q;
  logic [1:0]        out_src_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [1:0]        win_idx;
  logic              win_found;
  logic              load;

  // Ready reflects only fullness, so a full FIFO refuses even on a popping cycle
  assign bus.in_ready = ~full;
  assign push         = bus.in_valid & ~full;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_fifo
    rl_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (bus.in_data[i*WIDTH +: WIDTH]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  // Winner: first non-empty input after the last grant, wrapping around
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_IN; k++) begin
      if (!win_found && !empty[rr_index(last_grant, k, NUM_IN)]) begin
        win_found = 1'b1;
        win_idx   = rr_index(last_grant, k, NUM_IN);
      end
    end
  end

  // Refill the output stage when it is empty or being drained this cycle
  assign load = ((state == OS_EMPTY) || bus.out_ready) && win_found;

  // Only the winning FIFO is popped, and only on a load
  always_comb begin
    pop = '0;
    if (load) pop[win_idx] = 1'b1;
  end

  // Output stage: holds one packet, stable while the sink stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= OS_EMPTY;
      out_data_q <= '0;
      out_src_q  <= '0;
      last_grant <= 2'(NUM_IN - 1);
      cnt_q      <= '0;
    end else begin
      if ((state == OS_FULL) && bus.out_ready) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (load) begin
        out_data_q <= head[win_idx];
        out_src_q  <= win_idx;
        last_grant <= win_idx;
      end
      case (state)
        OS_EMPTY: if (load) state <= OS_FULL;
        OS_FULL:  if (bus.out_ready && !load) state <= OS_EMPTY;
        default:  state <= OS_EMPTY;
      endcase
    end
  end

  assign bus.out_valid = (state == OS_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.pkt_count = cnt_q;

endmodule

// File: tb/tb_rl_merge_arb.sv
// tb/tb_rl_merge_arb.sv - scoreboard bench for the merge arbiter
module tb_rl_merge_arb;

  localparam int N = 3;
  localparam int W = 11;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } sb_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  rl_merge_arb_if #(.WIDTH(W), .NUM_IN(N), .CNT_W(16)) bus ();

  rl_merge_arb #(
    .WIDTH      (W),
    .NUM_IN     (N),
    .FIFO_DEPTH (2),
    .CNT_W      (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sb_t         sb [N][$];
  int          tests    = 0;
  int          fails    = 0;
  int          cyc      = 0;
  int          hs_total = 0;
  int          acc [N];
  int          wait_cnt [N];
  logic [15:0] exp_cnt  = '0;
  bit          held     = 0;
  logic [W-1:0] held_data;
  logic [1:0]  held_src;
  bit          rr_mode    = 0;
  bit          rr_started = 0;
  int          last_src   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  function automatic logic [32:0] rnd();
    logic [32:0] r;
    r = {1'($urandom()), $urandom()};
    return r;
  endfunction

  // One cycle of stimulus; packets that will be accepted enter the scoreboard now
  task automatic drive(input logic [2:0] v, input logic [32:0] d, input logic ordy);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    for (int i = 0; i < N; i++) begin
      if (v[i] && bus.in_ready[i]) begin
        sb[i].push_back('{d[i*W +: W], cyc});
        acc[i]++;
      end
    end
  endtask

  // Monitor: output handshakes are checked against the per-input scoreboards
  initial begin
    int s;
    for (int i = 0; i < N; i++) begin
      acc[i] = 0;
      wait_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("pkt_count", 32'(bus.pkt_count), 32'(exp_cnt));
        if (held) begin
          chk("hold_valid", 32'(bus.out_valid), 1);
          chk("hold_data", 32'(bus.out_data), 32'(held_data));
          chk("hold_src", 32'(bus.out_src), 32'(held_src));
        end
      end
      #4;
      held = 0;
      if (!reset && bus.out_valid) begin
        if (bus.out_ready) begin
          s = int'(bus.out_src);
          hs_total++;
          exp_cnt = exp_cnt + 16'd1;
          if (s >= N) begin
            chk("out_src_range", 32'(s), 0);
          end else if (sb[s].size() == 0) begin
            chk("unexpected_pkt", 32'(bus.out_data), 32'h7fffffff);
          end else begin
            chk("out_data", 32'(bus.out_data), 32'(sb[s][0].data));
            void'(sb[s].pop_front());
            for (int j = 0; j < N; j++) begin
              if (j == s) wait_cnt[j] = 0;
              else if (sb[j].size() > 0 && sb[j][0].cyc < cyc) begin
                wait_cnt[j]++;
                if (wait_cnt[j] > N) chk("starvation", 32'(wait_cnt[j]), N);
              end else wait_cnt[j] = 0;
            end
          end
          if (rr_mode) begin
            if (rr_started) chk("rr_order", 32'(s), 32'((last_src + 1) % N));
            rr_started = 1;
            last_src   = s;
          end
        end else begin
          held      = 1;
          held_data = bus.out_data;
          held_src  = bus.out_src;
        end
      end
      if (rr_mode && rr_started && !reset) chk("throughput", 32'(bus.out_valid && bus.out_ready), 1);
    end
  end

  initial begin
    int a0;
    int k;
    logic [32:0] d;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h7);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_pkt_count", 32'(bus.pkt_count), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_src", 32'(bus.out_src), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Fairness and counter wrap: all inputs saturated, sink always ready
    rr_mode = 1;
    for (k = 0; k < 70000 && hs_total < 65536; k++) drive(3'b111, rnd(), 1'b1);
    chk("t5_budget", 32'(hs_total), 65536);
    rr_mode = 0;
    repeat (5) drive(3'b111, rnd(), 1'b0);
    chk("t5_hs_total", 32'(hs_total), 65537);
    chk("t5_wrap_count", 32'(bus.pkt_count), 1);
    chk("t1_all_full", 32'(bus.in_ready), 0);

    // Asynchronous reset in the middle of a cycle with everything full
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t1_out_valid", 32'(bus.out_valid), 0);
    chk("t1_pkt_count", 32'(bus.pkt_count), 0);
    chk("t1_in_ready", 32'(bus.in_ready), 32'h7);
    bus.in_valid = '0;
    for (int i = 0; i < N; i++) begin
      sb[i].delete();
      wait_cnt[i] = 0;
    end
    exp_cnt  = '0;
    hs_total = 0;
    held     = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(3'b000, '0, 1'b1);

    // Single packet latency on input 1
    d = '0;
    d[W +: W] = 11'h2A5;
    drive(3'b010, d, 1'b1);
    drive(3'b000, '0, 1'b1);
    chk("t2_not_yet", 32'(bus.out_valid), 0);
    drive(3'b000, '0, 1'b1);
    chk("t2_valid", 32'(bus.out_valid), 1);
    chk("t2_data", 32'(bus.out_data), 32'h2A5);
    chk("t2_src", 32'(bus.out_src), 1);
    drive(3'b000, '0, 1'b1);
    chk("t2_count", 32'(bus.pkt_count), 1);

    // Backpressure: output stage plus two FIFO entries fill, then ready drops
    a0 = acc[0];
    repeat (4) drive(3'b001, rnd(), 1'b0);
    drive(3'b000, '0, 1'b0);
    chk("t4_accepted", 32'(acc[0] - a0), 3);
    chk("t4_in_ready0", 32'(bus.in_ready[0]), 0);
    repeat (10) drive(3'b000, '0, 1'b0);
    chk("t4_still_valid", 32'(bus.out_valid), 1);
    repeat (6) drive(3'b000, '0, 1'b1);
    chk("t4_drained", 32'(sb[0].size()), 0);

    // Random traffic and sink stalls
    for (int c = 0; c < 10000; c++)
      drive(3'($urandom_range(0, 7)), rnd(), 1'($urandom_range(0, 3) != 0));
    for (k = 0; k < 60 && (sb[0].size() + sb[1].size() + sb[2].size()) > 0; k++)
      drive(3'b000, '0, 1'b1);
    for (int i = 0; i < N; i++) chk("t6_no_drop", 32'(sb[i].size()), 0);
    drive(3'b000, '0, 1'b1);
    chk("t6_idle", 32'(bus.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
